// File: rtl/fsmc_pkg.sv
// Shared FSMC definitions: bus widths, default phase timing, FSM states.
// Imported by the master, the slave fabric and the benches.
package fsmc_pkg;

    localparam int FSMC_ADDR_W  = 18;
    localparam int FSMC_DATA_W  = 16;

    localparam int FSMC_ADDSET  = 2;
    localparam int FSMC_ADDHLD  = 1;
    localparam int FSMC_DATAST  = 4;
    localparam int FSMC_BUSTURN = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AHOLD,
        ST_DATA,
        ST_TURN
    } fsmc_state_e;

    function automatic int fsmc_max4(input int a, input int b,
                                     input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// Loadable down-counter timing one bus phase; done while the count is 0.
// Holds at 0 until the next load.
module fsmc_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o = cnt_q;
    assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/fsmc_master.sv
// FSMC multiplexed-AD bus master: one valid/ready request becomes one
// NADV/NWE/NOE bus cycle with parameterised phase lengths.
module fsmc_master
    import fsmc_pkg::*;
#(
    parameter int ADDR_W  = FSMC_ADDR_W,
    parameter int DATA_W  = FSMC_DATA_W,
    parameter int ADDSET  = FSMC_ADDSET,
    parameter int ADDHLD  = FSMC_ADDHLD,
    parameter int DATAST  = FSMC_DATAST,
    parameter int BUSTURN = FSMC_BUSTURN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    inout  wire  [ADDR_W-1:0] AD,
    output logic              NADV,
    output logic              NWE,
    output logic              NOE
);

    if (ADDSET < 1 || ADDHLD < 1 || BUSTURN < 1 || DATAST < 2) begin : g_bad_timing
        $error("fsmc_master: ADDSET/ADDHLD/BUSTURN must be >= 1, DATAST >= 2");
    end
    if (DATA_W > ADDR_W) begin : g_bad_width
        $error("fsmc_master: DATA_W must not exceed ADDR_W");
    end

    localparam int TMAX = fsmc_max4(ADDSET, ADDHLD, DATAST, BUSTURN);
    localparam int TW   = $clog2(TMAX) + 1;

    fsmc_state_e       state_q;
    logic              nadv_q, nwe_q, noe_q;
    logic              ad_oe_q;
    logic [ADDR_W-1:0] ad_out_q;
    logic              ready_q, busy_q;
    logic              rsp_valid_q, rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic [TW-1:0]     tmr_cnt;
    logic              tmr_done;

    assign accept = req_valid & ready_q;

    fsmc_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .count_o (tmr_cnt),
        .done_o  (tmr_done)
    );

    // Each phase entry reloads the timer with its length minus one.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                tmr_load = accept;
                tmr_val  = TW'(ADDSET - 1);
            end
            ST_ADDR: begin
                tmr_load = tmr_done;
                tmr_val  = TW'(ADDHLD - 1);
            end
            ST_AHOLD: begin
                tmr_load = tmr_done;
                tmr_val  = TW'(DATAST - 1);
            end
            ST_DATA: begin
                tmr_load = tmr_done;
                tmr_val  = TW'(BUSTURN - 1);
            end
            ST_TURN: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nadv_q      <= 1'b1;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_ADDR;
                        wr_q     <= req_write;
                        wdata_q  <= req_wdata;
                        ad_out_q <= req_addr;
                        ad_oe_q  <= 1'b1;
                        nadv_q   <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (tmr_done) begin
                        state_q <= ST_AHOLD;
                        nadv_q  <= 1'b1;
                    end
                end
                ST_AHOLD: begin
                    if (tmr_done) begin
                        state_q <= ST_DATA;
                        if (wr_q) begin
                            nwe_q    <= 1'b0;
                            ad_out_q <= ADDR_W'(wdata_q);
                        end else begin
                            noe_q   <= 1'b0;
                            ad_oe_q <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    // Sample on the last strobe cycle while NOE is still low.
                    if (!wr_q && tmr_cnt == '0) begin
                        rsp_rdata_q <= AD[DATA_W-1:0];
                    end
                    if (tmr_done) begin
                        state_q     <= ST_TURN;
                        nwe_q       <= 1'b1;
                        noe_q       <= 1'b1;
                        ad_oe_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= wr_q;
                    end
                end
                ST_TURN: begin
                    if (tmr_done) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign AD        = ad_oe_q ? ad_out_q : {ADDR_W{1'bz}};
    assign NADV      = nadv_q;
    assign NWE       = nwe_q;
    assign NOE       = noe_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
